// File: rtl/freq_search_ctl.sv
`default_nettype none
// ============================================================================
// freq_search_ctl : NCO frequency-bin sweep controller reporting |I|+|Q| per bin
// Optional running peak tracker enabled by defining FREQ_SEARCH_PEAK_EN.  Rev 1.0
// ============================================================================
module freq_search_ctl #(
  parameter int          NUM_BINS   = 16,
  parameter int          SETTLE_LEN = 4,
  parameter int          WIN_LEN    = 256,
  parameter logic [12:0] CW_START   = 13'h0400,
  parameter logic [12:0] CW_STEP    = 13'h0040
) (
  input  logic        clk,
  input  logic        rst_in,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  i_value,
  input  logic [7:0]  q_value,
  output logic [12:0] control_word,
  output logic        corr_rst,
  output logic        busy,
  output logic        stb,
  output logic [7:0]  bin_idx,
  output logic [8:0]  bin_mag,
  output logic        done,
  output logic [7:0]  best_idx,
  output logic [8:0]  best_mag
);

  localparam logic [15:0] C_SETTLE_LAST = 16'(SETTLE_LEN - 1);
  localparam logic [15:0] C_WIN_LAST    = 16'(WIN_LEN - 1);
  localparam logic [7:0]  C_LAST_BIN    = 8'(NUM_BINS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_INTEG  = 3'd2,
    S_DUMP   = 3'd3,
    S_REPORT = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  state_e      state_q;
  logic [15:0] cnt_q;
  logic [12:0] cw_q;
  logic        corr_rst_q;
  logic        busy_q;
  logic        stb_q;
  logic        done_q;
  logic [7:0]  bin_idx_q;
  logic [8:0]  bin_mag_q;

  logic [8:0]  w_ext_i;
  logic [8:0]  w_ext_q;
  logic [8:0]  w_abs_i;
  logic [8:0]  w_abs_q;
  logic [8:0]  w_mag;

  // Sign-extend to 9 bits first so |-128| = 128 is representable.
  always_comb begin
    w_ext_i = {i_value[7], i_value};
    w_ext_q = {q_value[7], q_value};
    w_abs_i = w_ext_i[8] ? (~w_ext_i + 9'd1) : w_ext_i;
    w_abs_q = w_ext_q[8] ? (~w_ext_q + 9'd1) : w_ext_q;
    w_mag   = w_abs_i + w_abs_q;
  end

`ifdef FREQ_SEARCH_PEAK_EN
  logic [7:0] pk_idx_q;
  logic [8:0] pk_mag_q;
  logic [7:0] best_idx_q;
  logic [8:0] best_mag_q;
  logic       w_pk_take;

  // Strict greater-than keeps the lowest index on ties.
  assign w_pk_take = (bin_mag_q > pk_mag_q);
  assign best_idx  = best_idx_q;
  assign best_mag  = best_mag_q;
`else
  assign best_idx  = 8'd0;
  assign best_mag  = 9'd0;
`endif

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= S_IDLE;
      cnt_q      <= 16'd0;
      cw_q       <= CW_START;
      corr_rst_q <= 1'b1;
      busy_q     <= 1'b0;
      stb_q      <= 1'b0;
      done_q     <= 1'b0;
      bin_idx_q  <= 8'd0;
      bin_mag_q  <= 9'd0;
`ifdef FREQ_SEARCH_PEAK_EN
      pk_idx_q   <= 8'd0;
      pk_mag_q   <= 9'd0;
      best_idx_q <= 8'd0;
      best_mag_q <= 9'd0;
`endif
    end else begin
      stb_q  <= 1'b0;
      done_q <= 1'b0;
      if ((state_q != S_IDLE) && abort) begin
        state_q    <= S_IDLE;
        corr_rst_q <= 1'b1;
        busy_q     <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            corr_rst_q <= 1'b1;
            if (start) begin
              state_q   <= S_SETTLE;
              busy_q    <= 1'b1;
              cnt_q     <= 16'd0;
              bin_idx_q <= 8'd0;
              cw_q      <= CW_START;
`ifdef FREQ_SEARCH_PEAK_EN
              pk_idx_q  <= 8'd0;
              pk_mag_q  <= 9'd0;
`endif
            end
          end
          S_SETTLE: begin
            if (cnt_q == C_SETTLE_LAST) begin
              state_q    <= S_INTEG;
              cnt_q      <= 16'd0;
              corr_rst_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end
          S_INTEG: begin
            if (cnt_q == C_WIN_LAST) begin
              state_q    <= S_DUMP;
              cnt_q      <= 16'd0;
              corr_rst_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end
          S_DUMP: begin
            state_q   <= S_REPORT;
            bin_mag_q <= w_mag;
            stb_q     <= 1'b1;
          end
          S_REPORT: begin
`ifdef FREQ_SEARCH_PEAK_EN
            if (w_pk_take) begin
              pk_idx_q <= bin_idx_q;
              pk_mag_q <= bin_mag_q;
            end
`endif
            if (bin_idx_q == C_LAST_BIN) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
`ifdef FREQ_SEARCH_PEAK_EN
              best_idx_q <= w_pk_take ? bin_idx_q : pk_idx_q;
              best_mag_q <= w_pk_take ? bin_mag_q : pk_mag_q;
`endif
            end else begin
              state_q   <= S_SETTLE;
              cnt_q     <= 16'd0;
              bin_idx_q <= bin_idx_q + 8'd1;
              cw_q      <= cw_q + CW_STEP;
            end
          end
          S_DONE: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q    <= S_IDLE;
            corr_rst_q <= 1'b1;
            busy_q     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign control_word = cw_q;
  assign corr_rst     = corr_rst_q;
  assign busy         = busy_q;
  assign stb          = stb_q;
  assign done         = done_q;
  assign bin_idx      = bin_idx_q;
  assign bin_mag      = bin_mag_q;

endmodule
`default_nettype wire

// File: doc/freq_search_ctl.md
FREQ_SEARCH_CTL -- requirements
Module: freq_search_ctl

Interface
REQ-001 Parameter: NUM_BINS, 16, number of NCO frequency bins per sweep (2..256).
REQ-002 Parameter: SETTLE_LEN, 4, cycles correlators are held in reset after each NCO retune (1..255).
REQ-003 Parameter: WIN_LEN, 256, correlator integration window length in cycles (2..65535).
REQ-004 Parameter: CW_START, 13'h0400, NCO control word for bin 0.
REQ-005 Parameter: CW_STEP, 13'h0040, control word increment between bins.
REQ-006 Port: clk  input  1  single system clock, all logic on rising edge.
REQ-007 Port: rst_in  input  1  asynchronous, active-low reset.
REQ-008 Port: start  input  1  sweep request, sampled in IDLE only.
REQ-009 Port: abort  input  1  synchronous sweep cancel.
REQ-010 Port: i_value  input  8  I correlator result, signed two's complement.
REQ-011 Port: q_value  input  8  Q correlator result, signed two's complement.
REQ-012 Port: control_word  output  13  NCO frequency word.
REQ-013 Port: corr_rst  output  1  correlator reset/dump, active-high.
REQ-014 Port: busy  output  1  high in every state except IDLE.
REQ-015 Port: stb  output  1  one-cycle per-bin result strobe.
REQ-016 Port: bin_idx  output  8  index of the current/reported bin.
REQ-017 Port: bin_mag  output  9  |I|+|Q| of reported bin, valid with stb.
REQ-018 Port: done  output  1  one-cycle pulse at sweep completion.
REQ-019 Port: best_idx  output  8  bin index of maximum magnitude in last completed sweep.
REQ-020 Port: best_mag  output  9  maximum magnitude of last completed sweep.

Function
REQ-021 FSM states IDLE, SETTLE, INTEG, DUMP, REPORT, DONE; one state register.
REQ-022 IDLE: corr_rst=1; start=1 -> SETTLE, bin_idx=0, control_word=CW_START, settle counter cleared.
REQ-023 SETTLE: corr_rst=1 for exactly SETTLE_LEN cycles, then -> INTEG.
REQ-024 INTEG: corr_rst=0 for exactly WIN_LEN cycles, then -> DUMP.
REQ-025 DUMP (1 cycle): corr_rst=1; i_value/q_value sampled; bin_mag computed as |I|+|Q| in 9 bits (|-128|=128, max 256).
REQ-026 REPORT (1 cycle): stb=1 with bin_idx and bin_mag of the bin just integrated.
REQ-027 REPORT -> DONE if bin_idx==NUM_BINS-1; else -> SETTLE with bin_idx+1 and control_word+CW_STEP.
REQ-028 control_word addition wraps modulo 2^13.
REQ-029 Per-bin period is SETTLE_LEN+WIN_LEN+2 cycles; start-to-done is NUM_BINS x that +1 cycle.
REQ-030 DONE (1 cycle): done=1, -> IDLE; start in DONE ignored.
REQ-031 start outside IDLE is ignored; no queuing.
REQ-032 abort=1 in any non-IDLE state -> IDLE next cycle; no stb, no done, best_* unchanged; abort has priority over all transitions.
REQ-033 abort and start together in IDLE: start wins (abort has no effect in IDLE).
REQ-034 stb, done never asserted together; stb never high outside REPORT.

Reset
REQ-035 rst_in=0 asynchronously forces IDLE, corr_rst=1, busy=0, stb=0, done=0, control_word=CW_START, bin_idx=0, bin_mag=0, best_idx=0, best_mag=0.
REQ-036 Reset mid-sweep discards all partial results; first sweep after release requires a new start.

Configuration
REQ-037 Macro FREQ_SEARCH_PEAK_EN: defined -> running peak tracked per sweep (strict greater-than, lowest index wins ties), best_* updated only in DONE; undefined -> best_idx, best_mag held at 0 and no peak logic synthesized.

Verification (NUM_BINS=4, SETTLE_LEN=2, WIN_LEN=8, CW_START=13'h0400, CW_STEP=13'h0040)
REQ-038 start pulse, I/Q = (10,-5),(20,20),(-30,1),(0,0) per bin -> 4 stb with bin_mag 15,40,31,0; control_word 0400,0440,0480,04C0; done 49 cycles after start; best_idx=1, best_mag=40 (PEAK_EN).
REQ-039 I=-128, Q=-128 in a bin -> bin_mag=256.
REQ-040 Equal magnitudes 40 in bins 1 and 3 -> best_idx=1.
REQ-041 abort during INTEG of bin 2 -> IDLE next cycle, busy=0, no done, best_* keep prior sweep values.
REQ-042 rst_in low in REPORT -> stb drops immediately, all outputs at reset values; start during busy sweep ignored.
REQ-043 CW_START=13'h1FC0, CW_STEP=13'h0040 -> bin 1 control_word=13'h0000 (wrap).
